// File: rtl/tlb_op_unit.sv
// -----------------------------------------------------------------------------
// tlb_op_unit
//
// Sequencer for the MIPS TLB maintenance instructions (TLBR, TLBWI, TLBWR,
// TLBP). It accepts one op at a time from the MEM-stage issue logic, drives the
// mmu maintenance port, and returns results to CP0 as one-cycle write-back
// strobes. It also owns the CP0 Random register.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   op_valid, op_type    op request (00 TLBR, 01 TLBWI, 10 TLBWR, 11 TLBP)
//   op_ready, busy       accept indication / pipeline stall request
//   cp0_index, cp0_entry_hi, cp0_entry_lo0, cp0_entry_lo1
//                        CP0 source registers, latched at accept
//   cp0_wired, wired_we  Wired value and its write strobe (Random control)
//   random_o             current Random value
//   tlb_rw_index, tlb_rw_we, entry_hi_i, entry_lo1_i, entry_lo2_i
//                        mmu maintenance port outputs
//   entry_hi_o, entry_lo1_o, entry_lo2_o, tlb_p_index
//                        mmu read / probe results
//   done                 one-cycle completion pulse
//   cp0_index_we, cp0_index_wdata
//                        Index write-back (TLBP)
//   cp0_entry_we, cp0_entry_hi_wdata, cp0_entry_lo0_wdata, cp0_entry_lo1_wdata
//                        EntryHi/Lo0/Lo1 write-back (TLBR)
// -----------------------------------------------------------------------------
module tlb_op_unit #(
    parameter int TLB_ENTRIES = 16,
    parameter int IDX_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [1:0]       op_type,
    output logic             op_ready,
    output logic             busy,
    input  logic [31:0]      cp0_index,
    input  logic [31:0]      cp0_entry_hi,
    input  logic [31:0]      cp0_entry_lo0,
    input  logic [31:0]      cp0_entry_lo1,
    input  logic [IDX_W-1:0] cp0_wired,
    input  logic             wired_we,
    output logic [IDX_W-1:0] random_o,
    output logic [IDX_W-1:0] tlb_rw_index,
    output logic             tlb_rw_we,
    output logic [31:0]      entry_hi_i,
    output logic [31:0]      entry_lo1_i,
    output logic [31:0]      entry_lo2_i,
    input  logic [31:0]      entry_hi_o,
    input  logic [31:0]      entry_lo1_o,
    input  logic [31:0]      entry_lo2_o,
    input  logic [31:0]      tlb_p_index,
    output logic             done,
    output logic             cp0_index_we,
    output logic [31:0]      cp0_index_wdata,
    output logic             cp0_entry_we,
    output logic [31:0]      cp0_entry_hi_wdata,
    output logic [31:0]      cp0_entry_lo0_wdata,
    output logic [31:0]      cp0_entry_lo1_wdata
);

    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(TLB_ENTRIES - 1);

    localparam logic [1:0] OP_TLBR  = 2'b00;
    localparam logic [1:0] OP_TLBWI = 2'b01;
    localparam logic [1:0] OP_TLBWR = 2'b10;
    localparam logic [1:0] OP_TLBP  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_PROBE,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_random;

    // Only the low index bits of CP0 Index are meaningful to the TLB.
    logic w_unused;
    assign w_unused = ^cp0_index[31:IDX_W];

    assign op_ready = (r_state == S_IDLE);
    // The accept cycle itself already stalls the pipeline.
    assign busy     = (r_state != S_IDLE) || op_valid;
    assign random_o = r_random;

    // Random: free-running down-counter bounded below by Wired. A Wired write
    // or a Wired value at/above the top entry pins it to the top entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_random <= MAX_IDX;
        end else if (wired_we) begin
            r_random <= MAX_IDX;
        end else if (cp0_wired >= MAX_IDX) begin
            r_random <= MAX_IDX;
        end else if (r_random == cp0_wired) begin
            r_random <= MAX_IDX;
        end else begin
            r_random <= r_random - 1'b1;
        end
    end

    // Operation FSM. The mmu-port output registers double as the latched
    // copies of the CP0 operands, so later CP0 changes cannot disturb an
    // in-flight op. Strobes are set on the edge entering their state and
    // cleared on the edge leaving it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state             <= S_IDLE;
            tlb_rw_index        <= '0;
            tlb_rw_we           <= 1'b0;
            entry_hi_i          <= '0;
            entry_lo1_i         <= '0;
            entry_lo2_i         <= '0;
            done                <= 1'b0;
            cp0_index_we        <= 1'b0;
            cp0_index_wdata     <= '0;
            cp0_entry_we        <= 1'b0;
            cp0_entry_hi_wdata  <= '0;
            cp0_entry_lo0_wdata <= '0;
            cp0_entry_lo1_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (op_valid) begin
                        // TLBWR targets the Random value seen at accept.
                        tlb_rw_index <= (op_type == OP_TLBWR) ? r_random
                                                              : cp0_index[IDX_W-1:0];
                        entry_hi_i   <= cp0_entry_hi;
                        entry_lo1_i  <= cp0_entry_lo0;
                        entry_lo2_i  <= cp0_entry_lo1;
                        case (op_type)
                            OP_TLBR: begin
                                r_state <= S_READ;
                            end
                            OP_TLBWI, OP_TLBWR: begin
                                r_state   <= S_WRITE;
                                tlb_rw_we <= 1'b1;
                                done      <= 1'b1;
                            end
                            OP_TLBP: begin
                                r_state <= S_PROBE;
                            end
                            default: begin
                                r_state <= S_IDLE;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    tlb_rw_we <= 1'b0;
                    done      <= 1'b0;
                    r_state   <= S_IDLE;
                end
                S_READ: begin
                    cp0_entry_hi_wdata  <= entry_hi_o;
                    cp0_entry_lo0_wdata <= entry_lo1_o;
                    cp0_entry_lo1_wdata <= entry_lo2_o;
                    cp0_entry_we        <= 1'b1;
                    done                <= 1'b1;
                    r_state             <= S_DONE;
                end
                S_PROBE: begin
                    // mmu reports a miss in bit 31; the word is passed through.
                    cp0_index_wdata <= tlb_p_index;
                    cp0_index_we    <= 1'b1;
                    done            <= 1'b1;
                    r_state         <= S_DONE;
                end
                S_DONE: begin
                    cp0_entry_we <= 1'b0;
                    cp0_index_we <= 1'b0;
                    done         <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_op_unit.sv
// -----------------------------------------------------------------------------
// tb_tlb_op_unit
//
// Directed bench for tlb_op_unit. A small behavioural TLB array stands in for
// the mmu (combinational read at tlb_rw_index, write on clock when tlb_rw_we);
// the probe result is a bench-driven word. Inputs change and outputs are
// sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_tlb_op_unit;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic [1:0]  op_type;
    logic        op_ready;
    logic        busy;
    logic [31:0] cp0_index;
    logic [31:0] cp0_entry_hi;
    logic [31:0] cp0_entry_lo0;
    logic [31:0] cp0_entry_lo1;
    logic [3:0]  cp0_wired;
    logic        wired_we;
    logic [3:0]  random_o;
    logic [3:0]  tlb_rw_index;
    logic        tlb_rw_we;
    logic [31:0] entry_hi_i;
    logic [31:0] entry_lo1_i;
    logic [31:0] entry_lo2_i;
    logic [31:0] entry_hi_o;
    logic [31:0] entry_lo1_o;
    logic [31:0] entry_lo2_o;
    logic [31:0] tlb_p_index;
    logic        done;
    logic        cp0_index_we;
    logic [31:0] cp0_index_wdata;
    logic        cp0_entry_we;
    logic [31:0] cp0_entry_hi_wdata;
    logic [31:0] cp0_entry_lo0_wdata;
    logic [31:0] cp0_entry_lo1_wdata;

    int n_cmp = 0;
    int n_err = 0;

    tlb_op_unit #(
        .TLB_ENTRIES (16),
        .IDX_W       (4)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .op_valid            (op_valid),
        .op_type             (op_type),
        .op_ready            (op_ready),
        .busy                (busy),
        .cp0_index           (cp0_index),
        .cp0_entry_hi        (cp0_entry_hi),
        .cp0_entry_lo0       (cp0_entry_lo0),
        .cp0_entry_lo1       (cp0_entry_lo1),
        .cp0_wired           (cp0_wired),
        .wired_we            (wired_we),
        .random_o            (random_o),
        .tlb_rw_index        (tlb_rw_index),
        .tlb_rw_we           (tlb_rw_we),
        .entry_hi_i          (entry_hi_i),
        .entry_lo1_i         (entry_lo1_i),
        .entry_lo2_i         (entry_lo2_i),
        .entry_hi_o          (entry_hi_o),
        .entry_lo1_o         (entry_lo1_o),
        .entry_lo2_o         (entry_lo2_o),
        .tlb_p_index         (tlb_p_index),
        .done                (done),
        .cp0_index_we        (cp0_index_we),
        .cp0_index_wdata     (cp0_index_wdata),
        .cp0_entry_we        (cp0_entry_we),
        .cp0_entry_hi_wdata  (cp0_entry_hi_wdata),
        .cp0_entry_lo0_wdata (cp0_entry_lo0_wdata),
        .cp0_entry_lo1_wdata (cp0_entry_lo1_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural TLB array standing in for the mmu.
    logic [31:0] m_hi  [0:15];
    logic [31:0] m_lo0 [0:15];
    logic [31:0] m_lo1 [0:15];

    always @(posedge clk) begin
        if (tlb_rw_we) begin
            m_hi[tlb_rw_index]  <= entry_hi_i;
            m_lo0[tlb_rw_index] <= entry_lo1_i;
            m_lo1[tlb_rw_index] <= entry_lo2_i;
        end
    end

    assign entry_hi_o  = m_hi[tlb_rw_index];
    assign entry_lo1_o = m_lo0[tlb_rw_index];
    assign entry_lo2_o = m_lo1[tlb_rw_index];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [3:0] exp_rnd;
        rst           = 1'b1;
        op_valid      = 1'b0;
        op_type       = 2'b00;
        cp0_index     = '0;
        cp0_entry_hi  = '0;
        cp0_entry_lo0 = '0;
        cp0_entry_lo1 = '0;
        cp0_wired     = 4'd0;
        wired_we      = 1'b0;
        tlb_p_index   = '0;
        tick;
        tick;
        n_cmp++;
        if (random_o !== 4'd15) begin
            n_err++;
            $display("FAIL reset_random got=%0d exp=15", random_o);
        end
        n_cmp++;
        if ({tlb_rw_we, done, cp0_index_we, cp0_entry_we, busy} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_strobes got=%b exp=00000",
                     {tlb_rw_we, done, cp0_index_we, cp0_entry_we, busy});
        end
        n_cmp++;
        if ({tlb_rw_index, entry_hi_i, entry_lo1_i, entry_lo2_i, cp0_index_wdata,
             cp0_entry_hi_wdata, cp0_entry_lo0_wdata, cp0_entry_lo1_wdata} !== '0) begin
            n_err++;
            $display("FAIL reset_data got=nonzero exp=0 (idx=%0d hi=%h wd=%h)",
                     tlb_rw_index, entry_hi_i, cp0_entry_hi_wdata);
        end
        n_cmp++;
        if (op_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_op_ready got=%b exp=1", op_ready);
        end
        rst = 1'b0;
        // Idle with Wired=0: 15,14,...,0,15,14
        for (int i = 1; i <= 20; i++) begin
            tick;
            exp_rnd = 4'(15 - i);
            n_cmp++;
            if (random_o !== exp_rnd ||
                {tlb_rw_we, done, cp0_index_we, cp0_entry_we, busy} !== 5'b0) begin
                n_err++;
                $display("FAIL idle_random cyc=%0d got=%0d/%b exp=%0d/00000", i, random_o,
                         {tlb_rw_we, done, cp0_index_we, cp0_entry_we, busy}, exp_rnd);
            end
        end
    endtask

    task automatic test_tlbwi;
        cp0_index     = 32'd5;
        cp0_entry_hi  = 32'h0000_2001;
        cp0_entry_lo0 = 32'h0000_0106;
        cp0_entry_lo1 = 32'h0000_0146;
        op_type       = 2'b01;
        op_valid      = 1'b1;
        #1;
        n_cmp++;
        if ({busy, op_ready} !== 2'b11) begin
            n_err++;
            $display("FAIL twi_accept busy/ready got=%b exp=11", {busy, op_ready});
        end
        tick;
        // Scramble CP0 to confirm the in-flight op uses latched copies.
        op_valid      = 1'b0;
        cp0_index     = 32'd7;
        cp0_entry_hi  = 32'hDEAD_BEEF;
        cp0_entry_lo0 = 32'h1111_1111;
        cp0_entry_lo1 = 32'h2222_2222;
        n_cmp++;
        if ({tlb_rw_we, done, busy, op_ready} !== 4'b1110 || tlb_rw_index !== 4'd5) begin
            n_err++;
            $display("FAIL twi_write we/done/busy/ready=%b idx=%0d exp=1110 idx=5",
                     {tlb_rw_we, done, busy, op_ready}, tlb_rw_index);
        end
        n_cmp++;
        if ({entry_hi_i, entry_lo1_i, entry_lo2_i} !==
            {32'h0000_2001, 32'h0000_0106, 32'h0000_0146}) begin
            n_err++;
            $display("FAIL twi_words got=%h/%h/%h exp=00002001/00000106/00000146",
                     entry_hi_i, entry_lo1_i, entry_lo2_i);
        end
        tick;
        n_cmp++;
        if ({tlb_rw_we, done, busy, op_ready} !== 4'b0001) begin
            n_err++;
            $display("FAIL twi_after we/done/busy/ready got=%b exp=0001",
                     {tlb_rw_we, done, busy, op_ready});
        end
    endtask

    task automatic test_tlbwr_random;
        logic [3:0] exp_rnd;
        cp0_wired = 4'd4;
        wired_we  = 1'b1;
        tick;
        wired_we = 1'b0;
        n_cmp++;
        if (random_o !== 4'd15) begin
            n_err++;
            $display("FAIL wired_we_reload got=%0d exp=15", random_o);
        end
        for (int i = 0; i < 6; i++) tick;
        n_cmp++;
        if (random_o !== 4'd9) begin
            n_err++;
            $display("FAIL twr_random_at_accept got=%0d exp=9", random_o);
        end
        cp0_index     = 32'd2;
        cp0_entry_hi  = 32'h0000_3002;
        cp0_entry_lo0 = 32'h0000_0206;
        cp0_entry_lo1 = 32'h0000_0246;
        op_type       = 2'b10;
        op_valid      = 1'b1;
        tick;
        op_valid = 1'b0;
        n_cmp++;
        if (tlb_rw_we !== 1'b1 || tlb_rw_index !== 4'd9 || random_o !== 4'd8) begin
            n_err++;
            $display("FAIL twr_write we=%b idx=%0d rnd=%0d exp we=1 idx=9 rnd=8",
                     tlb_rw_we, tlb_rw_index, random_o);
        end
        tick;
        n_cmp++;
        if (tlb_rw_we !== 1'b0 || random_o !== 4'd7) begin
            n_err++;
            $display("FAIL twr_after we=%b rnd=%0d exp we=0 rnd=7", tlb_rw_we, random_o);
        end
        exp_rnd = 4'd7;
        for (int i = 0; i < 40; i++) begin
            tick;
            exp_rnd = (exp_rnd == 4'd4) ? 4'd15 : exp_rnd - 4'd1;
            n_cmp++;
            if (random_o !== exp_rnd || random_o < 4'd4) begin
                n_err++;
                $display("FAIL wired_floor cyc=%0d got=%0d exp=%0d", i, random_o, exp_rnd);
            end
        end
    endtask

    task automatic test_tlbr;
        cp0_index = 32'd5;
        op_type   = 2'b00;
        op_valid  = 1'b1;
        tick;
        op_valid  = 1'b0;
        cp0_index = 32'd9;
        n_cmp++;
        if ({tlb_rw_we, done, cp0_entry_we, busy} !== 4'b0001 || tlb_rw_index !== 4'd5) begin
            n_err++;
            $display("FAIL tlbr_read we/done/ewe/busy=%b idx=%0d exp=0001 idx=5",
                     {tlb_rw_we, done, cp0_entry_we, busy}, tlb_rw_index);
        end
        tick;
        n_cmp++;
        if ({cp0_entry_we, done, cp0_index_we} !== 3'b110) begin
            n_err++;
            $display("FAIL tlbr_done ewe/done/iwe got=%b exp=110",
                     {cp0_entry_we, done, cp0_index_we});
        end
        n_cmp++;
        if ({cp0_entry_hi_wdata, cp0_entry_lo0_wdata, cp0_entry_lo1_wdata} !==
            {32'h0000_2001, 32'h0000_0106, 32'h0000_0146}) begin
            n_err++;
            $display("FAIL tlbr_wdata got=%h/%h/%h exp=00002001/00000106/00000146",
                     cp0_entry_hi_wdata, cp0_entry_lo0_wdata, cp0_entry_lo1_wdata);
        end
        tick;
        n_cmp++;
        if ({cp0_entry_we, done, op_ready} !== 3'b001 ||
            cp0_entry_hi_wdata !== 32'h0000_2001) begin
            n_err++;
            $display("FAIL tlbr_hold ewe/done/ready=%b hi=%h exp=001 hi=00002001",
                     {cp0_entry_we, done, op_ready}, cp0_entry_hi_wdata);
        end
    endtask

    task automatic test_tlbp;
        // Hit
        cp0_entry_hi = 32'h0000_2001;
        tlb_p_index  = 32'h0000_0005;
        op_type      = 2'b11;
        op_valid     = 1'b1;
        tick;
        op_valid     = 1'b0;
        cp0_entry_hi = 32'hFFFF_0000;
        n_cmp++;
        if (entry_hi_i !== 32'h0000_2001 || {done, cp0_index_we, tlb_rw_we} !== 3'b000) begin
            n_err++;
            $display("FAIL tlbp_probe hi=%h done/iwe/we=%b exp hi=00002001 000",
                     entry_hi_i, {done, cp0_index_we, tlb_rw_we});
        end
        tick;
        n_cmp++;
        if ({cp0_index_we, done, cp0_entry_we} !== 3'b110 ||
            cp0_index_wdata !== 32'h0000_0005) begin
            n_err++;
            $display("FAIL tlbp_hit iwe/done/ewe=%b wdata=%h exp=110 wdata=00000005",
                     {cp0_index_we, done, cp0_entry_we}, cp0_index_wdata);
        end
        tick;
        n_cmp++;
        if (cp0_index_we !== 1'b0 || cp0_index_wdata !== 32'h0000_0005) begin
            n_err++;
            $display("FAIL tlbp_hold iwe=%b wdata=%h exp iwe=0 wdata=00000005",
                     cp0_index_we, cp0_index_wdata);
        end
        // Miss
        tlb_p_index = 32'h8000_0000;
        op_valid    = 1'b1;
        tick;
        op_valid = 1'b0;
        tick;
        n_cmp++;
        if (cp0_index_we !== 1'b1 || cp0_index_wdata !== 32'h8000_0000) begin
            n_err++;
            $display("FAIL tlbp_miss iwe=%b wdata=%h exp iwe=1 wdata=80000000",
                     cp0_index_we, cp0_index_wdata);
        end
        tick;
    endtask

    task automatic test_reset_in_read;
        cp0_index = 32'd5;
        op_type   = 2'b00;
        op_valid  = 1'b1;
        tick;
        op_valid = 1'b0;
        rst      = 1'b1;
        tick;
        rst = 1'b0;
        n_cmp++;
        if ({cp0_entry_we, done, busy, op_ready} !== 4'b0001) begin
            n_err++;
            $display("FAIL rst_in_read ewe/done/busy/ready got=%b exp=0001",
                     {cp0_entry_we, done, busy, op_ready});
        end
        tick;
        n_cmp++;
        if ({cp0_entry_we, done, op_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL rst_in_read_after ewe/done/ready got=%b exp=001",
                     {cp0_entry_we, done, op_ready});
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] w_ready;
        logic [8:0] r_ready;
        int         n_done;
        // Writes: accept every 2 cycles
        cp0_index = 32'd3;
        op_type   = 2'b01;
        op_valid  = 1'b1;
        n_done    = 0;
        for (int i = 0; i < 8; i++) begin
            w_ready[7-i] = op_ready;
            tick;
            if (done) n_done++;
        end
        op_valid = 1'b0;
        n_cmp++;
        if (w_ready !== 8'b1010_1010 || n_done != 4) begin
            n_err++;
            $display("FAIL b2b_write ready=%b done=%0d exp=10101010 done=4", w_ready, n_done);
        end
        tick;
        // Reads: accept every 3 cycles
        cp0_index = 32'd5;
        op_type   = 2'b00;
        op_valid  = 1'b1;
        n_done    = 0;
        for (int i = 0; i < 9; i++) begin
            r_ready[8-i] = op_ready;
            tick;
            if (done) n_done++;
        end
        op_valid = 1'b0;
        n_cmp++;
        if (r_ready !== 9'b100_100_100 || n_done != 3) begin
            n_err++;
            $display("FAIL b2b_read ready=%b done=%0d exp=100100100 done=3", r_ready, n_done);
        end
        tick;
        n_cmp++;
        if ({busy, op_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL b2b_idle busy/ready got=%b exp=01", {busy, op_ready});
        end
    endtask

    initial begin
        test_reset;
        test_tlbwi;
        test_tlbwr_random;
        test_tlbr;
        test_tlbp;
        test_reset_in_read;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
